// File: rtl/cdec8_pkg.sv
// Shared types and constants for the result-dump block: FSM states,
// per-location character positions, ASCII constants and the nibble-to-hex helper.
package cdec8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    DONE
  } state_e;

  // Position inside the character stream of one location (plus trailer and drain).
  typedef enum logic [2:0] {
    POS_HI,
    POS_LO,
    POS_SP,
    POS_CR,
    POS_LF,
    POS_DRAIN
  } pos_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (ASCII_A + {4'd0, n} - 8'd10);
  endfunction

endpackage

// File: rtl/cdec8_uart_tx.sv
// 8N1 UART transmitter; a character is accepted on start only while ready=1.
// Registered tx output, down-counting bit timer reloaded with BIT_TICKS-1.
module cdec8_uart_tx #(
  parameter int BIT_TICKS = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LOAD = CW'(BIT_TICKS - 1);

  logic          active_q, active_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;

  // bit_q counts the bits still to follow the one on the line: 9 = start bit, 0 = stop bit.
  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        tx_d     = 1'b0;
        shift_d  = data;
        bit_d    = 4'd9;
        baud_d   = TICK_LOAD;
      end
    end else if (baud_q != '0) begin
      baud_d = baud_q - 1'b1;
    end else if (bit_q == 4'd0) begin
      active_d = 1'b0;
      tx_d     = 1'b1;
    end else begin
      tx_d    = shift_q[0];
      shift_d = {1'b1, shift_q[7:1]};
      bit_d   = bit_q - 4'd1;
      baud_d  = TICK_LOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
    end
  end

  assign tx    = tx_q;
  assign ready = !active_q;

endmodule

// File: rtl/cdec8_res_dump.sv
// Dumps core result memory over UART once per endseq assertion.
// RES_DUMP_HEX_EN selects ASCII hex ("HH " per location, CR LF trailer); default is raw bytes.
module cdec8_res_dump
  import cdec8_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 115200,
  parameter int DUMP_LEN = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       endseq,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_TICKS = CLK_HZ / BAUD;
  // 9-bit index so DUMP_LEN=256 compares against 255 without wrapping.
  localparam logic [8:0] LAST_IDX = 9'(DUMP_LEN - 1);

  state_e     state_q, state_d;
  pos_e       pos_q, pos_d;
  logic [8:0] idx_q, idx_d;
  logic [7:0] resad_q, resad_d;
  logic [7:0] byte_q, byte_d;
  logic       tx_start, tx_ready;
  logic [7:0] chr;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    idx_d    = idx_q;
    resad_d  = resad_q;
    byte_d   = byte_q;
    tx_start = 1'b0;
    chr      = byte_q;
    case (state_q)
      IDLE: begin
        if (endseq) begin
          state_d = FETCH;
          idx_d   = '0;
          resad_d = '0;
          pos_d   = POS_HI;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        byte_d  = resdt;
        state_d = SEND;
      end
      SEND: begin
`ifdef RES_DUMP_HEX_EN
        case (pos_q)
          POS_HI:  chr = hex_ascii(byte_q[7:4]);
          POS_LO:  chr = hex_ascii(byte_q[3:0]);
          POS_CR:  chr = ASCII_CR;
          POS_LF:  chr = ASCII_LF;
          default: chr = ASCII_SPACE;
        endcase
`endif
        if (pos_q == POS_DRAIN) begin
          if (tx_ready) state_d = DONE;
        end else if (tx_ready) begin
          tx_start = 1'b1;
`ifdef RES_DUMP_HEX_EN
          case (pos_q)
            POS_HI: pos_d = POS_LO;
            POS_LO: pos_d = POS_SP;
            POS_SP: begin
              if (idx_q == LAST_IDX) begin
                pos_d = POS_CR;
              end else begin
                idx_d   = idx_q + 9'd1;
                resad_d = idx_d[7:0];
                pos_d   = POS_HI;
                state_d = FETCH;
              end
            end
            POS_CR:  pos_d = POS_LF;
            default: pos_d = POS_DRAIN;
          endcase
`else
          if (idx_q == LAST_IDX) begin
            pos_d = POS_DRAIN;
          end else begin
            idx_d   = idx_q + 9'd1;
            resad_d = idx_d[7:0];
            state_d = FETCH;
          end
`endif
        end
      end
      DONE:    if (!endseq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= POS_HI;
      idx_q   <= '0;
      resad_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      resad_q <= resad_d;
      byte_q  <= byte_d;
    end
  end

  cdec8_uart_tx #(.BIT_TICKS(BIT_TICKS)) u_uart (
    .clock (clock),
    .reset (reset),
    .start (tx_start),
    .data  (chr),
    .tx    (tx),
    .ready (tx_ready)
  );

  // busy falls the moment the final stop bit ends, one cycle before DONE is entered.
  assign busy  = ((state_q == FETCH) || (state_q == CAPTURE) || (state_q == SEND)) &&
                 !((state_q == SEND) && (pos_q == POS_DRAIN) && tx_ready);
  assign done  = (state_q == DONE);
  assign resad = resad_q;

endmodule

// File: doc/cdec8_res_dump.md
CDEC8_RES_DUMP -- requirements
Module: cdec8_res_dump

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: UART bit rate.
REQ-003 SHALL have parameter DUMP_LEN, default 16: number of result locations dumped, legal range 1..256.
REQ-004 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port endseq, input, 1: core program-finished flag, level.
REQ-007 SHALL have port resad, output, 8: result address presented to the core.
REQ-008 SHALL have port resdt, input, 8: result data returned by the core, combinationally valid for the current resad.
REQ-009 SHALL have port tx, output, 1: UART serial out, idle high.
REQ-010 SHALL have port busy, output, 1: high from trigger until the last stop bit ends.
REQ-011 SHALL have port done, output, 1: high in DONE state.

Function
REQ-012 SHALL use FSM states IDLE, FETCH, CAPTURE, SEND, DONE.
REQ-013 SHALL move IDLE->FETCH on any edge with endseq=1; idx cleared to 0.
REQ-014 SHALL drive resad=idx in FETCH, latch resdt into byte register in CAPTURE (one cycle later), then enter SEND.
REQ-015 SHALL in SEND (hex mode) emit, per location, upper nibble ASCII, lower nibble ASCII, then 0x20; hex digits uppercase (0x30-0x39, 0x41-0x46).
REQ-016 SHALL after the last location (idx=DUMP_LEN-1) emit 0x0D then 0x0A, then enter DONE; otherwise increment idx and return to FETCH.
REQ-017 SHALL frame each character as start bit 0, 8 data bits LSB first, stop bit 1, each bit lasting BIT_TICKS=CLK_HZ/BAUD (integer division) cycles.
REQ-018 SHALL start the next character's start bit no later than 3 cycles after the previous stop bit ends.
REQ-019 SHALL hold resad constant from FETCH until the next FETCH; resad wraps to 0 only via reset or new dump.
REQ-020 SHALL stay in DONE (done=1, busy=0, tx=1) while endseq=1 and return to IDLE on the first edge with endseq=0, so one dump occurs per endseq assertion.
REQ-021 SHALL ignore endseq changes during FETCH/CAPTURE/SEND; an in-progress dump always completes.
REQ-022 SHALL with DUMP_LEN=256 use a 9-bit index internally so the terminal compare does not wrap.

Reset
REQ-023 SHALL on the edge with reset=1 force state IDLE, idx=0, resad=0, tx=1, busy=0, done=0, baud and bit counters 0, regardless of state, including mid-character.
REQ-024 SHALL start a dump on the first edge after reset release if endseq=1.

Configuration
REQ-025 SHALL with RES_DUMP_HEX_EN defined use the ASCII hex format of REQ-015/016 (3*DUMP_LEN+2 characters).
REQ-026 SHALL without RES_DUMP_HEX_EN send each result as one raw binary byte, no separators, no CR/LF (DUMP_LEN frames).

Structure
REQ-027 SHALL place the FSM state enum and the ASCII constants (space, CR, LF, '0', 'A') in shared package cdec8_pkg.
REQ-028 SHALL implement serialisation in sub-module cdec8_uart_tx (ports clock, reset, start, data[7:0], tx, ready), start accepted only when ready=1.

Verification (CLK_HZ=4, BAUD=1 so BIT_TICKS=4; HEX on unless stated)
REQ-029 SHALL check DUMP_LEN=2, resdt=0xA5 at 0 and 0x3C at 1, endseq raised: tx decodes "A5 3C \r\n" (0x41,0x35,0x20,0x33,0x43,0x20,0x0D,0x0A), done=1 afterwards.
REQ-030 SHALL check each frame is 40 cycles: start bit low 4 cycles, stop bit high 4 cycles, resad steps 0 then 1.
REQ-031 SHALL check endseq held high after DONE gives no second dump; endseq 0 then 1 gives exactly one repeat dump.
REQ-032 SHALL check reset pulsed mid data bit of second character: next edge tx=1, busy=0, resad=0, and the dump restarts if endseq=1.
REQ-033 SHALL check without RES_DUMP_HEX_EN, DUMP_LEN=3, data 0x00,0xFF,0x80: exactly three frames carrying 0x00,0xFF,0x80.
REQ-034 SHALL check DUMP_LEN=256: resad reaches 0xFF, 770 characters are sent, and the FSM terminates in DONE.
